cpu_controller: RTL and testbench

- Phase-sequencing control unit for the 8-bit RISC CPU.
- Consumes the 3-bit op_code held in the instruction register and the accumulator zero flag.
- Steps through a fixed 8-phase instruction cycle and drives every datapath control strobe, including ld_ir back to the instruction register.
- Sits directly downstream of the instruction register and upstream of the PC, memory, accumulator and ALU.

---
 rtl/cpu_controller.sv | 121 ++++++++++++
 tb/tb_cpu_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// Phase-sequencing control unit for the 8-bit RISC CPU.
// Steps an 8-phase instruction cycle and decodes every datapath strobe from phase, opcode and zero flag.
module cpu_controller #(
    parameter int OP_CODE_WIDTH = 3,
    parameter int PHASE_WIDTH   = 3
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     en,
    input  logic [OP_CODE_WIDTH-1:0] op_code,
    input  logic                     zero,
    output logic                     sel,
    output logic                     rd,
    output logic                     ld_ir,
    output logic                     inc_pc,
    output logic                     ld_pc,
    output logic                     ld_ac,
    output logic                     wr,
    output logic                     data_e,
    output logic                     halt,
    output logic [PHASE_WIDTH-1:0]   phase
);

    typedef enum logic [PHASE_WIDTH-1:0] {
        INST_ADDR  = 'd0,
        INST_FETCH = 'd1,
        INST_LOAD  = 'd2,
        IDLE       = 'd3,
        OP_ADDR    = 'd4,
        OP_FETCH   = 'd5,
        ALU_OP     = 'd6,
        STORE      = 'd7
    } phase_t;

    localparam logic [OP_CODE_WIDTH-1:0] OP_HLT = 'd0;
    localparam logic [OP_CODE_WIDTH-1:0] OP_SKZ = 'd1;
    localparam logic [OP_CODE_WIDTH-1:0] OP_ADD = 'd2;
    localparam logic [OP_CODE_WIDTH-1:0] OP_AND = 'd3;
    localparam logic [OP_CODE_WIDTH-1:0] OP_XOR = 'd4;
    localparam logic [OP_CODE_WIDTH-1:0] OP_LDA = 'd5;
    localparam logic [OP_CODE_WIDTH-1:0] OP_STO = 'd6;
    localparam logic [OP_CODE_WIDTH-1:0] OP_JMP = 'd7;

    phase_t phase_q;
    logic   halted_q;
    logic   is_hlt;
    logic   is_alu;

    // Opcode is decoded live from the IR; it is never latched here.
    assign is_hlt = (op_code == OP_HLT);
    assign is_alu = (op_code == OP_ADD) || (op_code == OP_AND) ||
                    (op_code == OP_XOR) || (op_code == OP_LDA);

    // A halt seen on an enabled edge in OP_ADDR freezes the phase there until reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else if (en && !halted_q) begin
            if (phase_q == OP_ADDR && is_hlt) begin
                halted_q <= 1'b1;
            end else begin
                phase_q <= phase_t'(phase_q + 1'b1);
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = halted_q;
        if (!halted_q) begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    rd = is_alu;
                end
                ALU_OP: begin
                    rd     = is_alu;
                    inc_pc = (op_code == OP_SKZ) && zero;
                    ld_pc  = (op_code == OP_JMP);
                    data_e = (op_code == OP_STO);
                end
                STORE: begin
                    rd     = is_alu;
                    ld_ac  = is_alu;
                    ld_pc  = (op_code == OP_JMP);
                    wr     = (op_code == OP_STO);
                    data_e = (op_code == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-phase strobe tables for each opcode, hold, halt and async reset.
module tb_cpu_controller;

    logic       clk;
    logic       n_rst;
    logic       en;
    logic [2:0] op_code;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe bundle order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    logic [8:0] strobes;
    logic [8:0] exp_tab [8];

    cpu_controller #(.OP_CODE_WIDTH(3), .PHASE_WIDTH(3)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .op_code(op_code), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
    );

    assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with phase 0; returns at a falling edge with phase 0 again.
    task automatic run_cycle(input string name);
        for (int p = 0; p < 8; p++) begin
            check($sformatf("%s phase%0d", name, p), 16'(phase), 16'(p));
            check($sformatf("%s strobes%0d", name, p), 16'(strobes), 16'(exp_tab[p]));
            @(negedge clk);
        end
    endtask

    task automatic load_fetch_rows();
        exp_tab[0] = 9'b1_0_0_0_0_0_0_0_0;
        exp_tab[1] = 9'b1_1_0_0_0_0_0_0_0;
        exp_tab[2] = 9'b1_1_1_0_0_0_0_0_0;
        exp_tab[3] = 9'b1_1_1_0_0_0_0_0_0;
        exp_tab[4] = 9'b0_0_0_1_0_0_0_0_0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst   = 1'b0;
        en      = 1'b1;
        op_code = 3'd2;
        zero    = 1'b0;
        #1;
        check("reset phase", 16'(phase), 16'd0);
        check("reset strobes", 16'(strobes), 16'(9'b1_0_0_0_0_0_0_0_0));
        repeat (2) @(posedge clk);
        #1;
        check("reset holds phase", 16'(phase), 16'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // ADD full cycle
        load_fetch_rows();
        exp_tab[5] = 9'b0_1_0_0_0_0_0_0_0;
        exp_tab[6] = 9'b0_1_0_0_0_0_0_0_0;
        exp_tab[7] = 9'b0_1_0_0_0_1_0_0_0;
        run_cycle("ADD");

        // STO
        op_code = 3'd6;
        load_fetch_rows();
        exp_tab[5] = 9'b0_0_0_0_0_0_0_0_0;
        exp_tab[6] = 9'b0_0_0_0_0_0_0_1_0;
        exp_tab[7] = 9'b0_0_0_0_0_0_1_1_0;
        run_cycle("STO");

        // SKZ, zero=1
        op_code = 3'd1;
        zero    = 1'b1;
        load_fetch_rows();
        exp_tab[5] = 9'b0_0_0_0_0_0_0_0_0;
        exp_tab[6] = 9'b0_0_0_1_0_0_0_0_0;
        exp_tab[7] = 9'b0_0_0_0_0_0_0_0_0;
        run_cycle("SKZ_z1");

        // SKZ, zero=0
        zero = 1'b0;
        exp_tab[6] = 9'b0_0_0_0_0_0_0_0_0;
        run_cycle("SKZ_z0");

        // JMP
        op_code = 3'd7;
        load_fetch_rows();
        exp_tab[5] = 9'b0_0_0_0_0_0_0_0_0;
        exp_tab[6] = 9'b0_0_0_0_1_0_0_0_0;
        exp_tab[7] = 9'b0_0_0_0_1_0_0_0_0;
        run_cycle("JMP");

        // Hold at phase 3 with en=0, then release
        op_code = 3'd2;
        repeat (3) @(negedge clk);
        check("pre-hold phase", 16'(phase), 16'd3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold phase %0d", i), 16'(phase), 16'd3);
            check($sformatf("hold ld_ir %0d", i), 16'(ld_ir), 16'd1);
        end
        en = 1'b1;
        @(negedge clk);
        check("release phase", 16'(phase), 16'd4);

        // Async reset mid-cycle at phase 6 with JMP
        op_code = 3'd7;
        repeat (2) @(negedge clk);
        check("jmp p6 phase", 16'(phase), 16'd6);
        check("jmp p6 ld_pc", 16'(ld_pc), 16'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async rst phase", 16'(phase), 16'd0);
        check("async rst strobes", 16'(strobes), 16'(9'b1_0_0_0_0_0_0_0_0));
        @(negedge clk);
        n_rst = 1'b1;

        // HLT: run to phase 4, hold it there with en=0, then let it halt
        op_code = 3'd0;
        repeat (4) @(negedge clk);
        check("hlt p4 phase", 16'(phase), 16'd4);
        check("hlt p4 strobes", 16'(strobes), 16'(9'b0_0_0_1_0_0_0_0_1));
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("hlt en0 phase", 16'(phase), 16'd4);
        check("hlt en0 strobes", 16'(strobes), 16'(9'b0_0_0_1_0_0_0_0_1));
        en = 1'b1;
        @(negedge clk);
        check("halted phase", 16'(phase), 16'd4);
        check("halted strobes", 16'(strobes), 16'(9'b0_0_0_0_0_0_0_0_1));
        op_code = 3'd2;
        for (int i = 0; i < 20; i++) begin
            en = i[0];
            @(negedge clk);
            check($sformatf("halted phase %0d", i), 16'(phase), 16'd4);
            check($sformatf("halted strobes %0d", i), 16'(strobes), 16'(9'b0_0_0_0_0_0_0_0_1));
        end
        #2;
        n_rst = 1'b0;
        #1;
        check("halt rst phase", 16'(phase), 16'd0);
        check("halt rst strobes", 16'(strobes), 16'(9'b1_0_0_0_0_0_0_0_0));
        @(negedge clk);
        n_rst = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check("post-halt advance", 16'(phase), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
